decimating_boxcar_averager: RTL and testbench

Upstream pre-averager for the n-sample moving-average filter in the OPO lock path. It sums 2^k consecutive signed ADC samples, emits their mean as one word plus a one-cycle valid strobe, then restarts. This produces the sparse signal_in / signal_in_valid stream the moving-average stage consumes. The result is a block (non-overlapping) decimation, so the downstream FIFO depth covers 2^k times more time.

---
 rtl/decimating_boxcar_averager_pkg.sv | 23 ++
 rtl/decimating_boxcar_averager.sv | 98 +++++++++
 tb/tb_decimating_boxcar_averager.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/decimating_boxcar_averager_pkg.sv
// Shared widths, FSM state type and the decimation-shift clamp for the
// OPO lock-path pre-averager.
package decimating_boxcar_averager_pkg;

    localparam int word_width       = 16;
    localparam int config_reg_width = 8;
    localparam int decim_max_shift  = 10;
    localparam int shift_width      = 4;

    typedef enum logic {
        S_FLUSH = 1'b0,
        S_ACCUM = 1'b1
    } decim_state_t;

    function automatic logic [shift_width-1:0] clamp_shift(input logic [31:0] cfg,
                                                           input int max_shift);
        if (cfg > 32'(max_shift)) begin
            return shift_width'(max_shift);
        end
        return shift_width'(cfg);
    endfunction

endpackage

// File: rtl/decimating_boxcar_averager.sv
// Block (non-overlapping) boxcar averager: sums 2^shift signed samples and
// emits their floor mean with a one-cycle strobe, then restarts.
module decimating_boxcar_averager
    import decimating_boxcar_averager_pkg::*;
#(
    parameter int WIDTH     = word_width,
    parameter int MAX_SHIFT = decim_max_shift,
    parameter int CFG_WIDTH = config_reg_width
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [CFG_WIDTH-1:0] decim_shift,
    input  logic [WIDTH-1:0]     adc_in,
    input  logic                 adc_in_valid,
    output logic [WIDTH-1:0]     signal_out,
    output logic                 signal_out_valid,
    output logic                 settled
);

    localparam int ACC_W = WIDTH + MAX_SHIFT;

    decim_state_t            state, state_n;
    logic [shift_width-1:0]  shift_cfg, shift_int, shift_int_n;
    logic signed [ACC_W-1:0] acc, acc_n, sum;
    logic [MAX_SHIFT-1:0]    cnt, cnt_n, last_cnt;
    logic [MAX_SHIFT:0]      blk_len;
    logic [WIDTH-1:0]        signal_out_n;
    logic                    valid_n, settled_n;

    assign shift_cfg = clamp_shift(32'(decim_shift), MAX_SHIFT);
    assign sum       = acc + $signed({{MAX_SHIFT{adc_in[WIDTH-1]}}, adc_in});
    assign blk_len   = (MAX_SHIFT+1)'(1) << shift_int;
    assign last_cnt  = MAX_SHIFT'(blk_len - (MAX_SHIFT+1)'(1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state            <= S_FLUSH;
            shift_int        <= shift_cfg;
            acc              <= '0;
            cnt              <= '0;
            signal_out       <= '0;
            signal_out_valid <= 1'b0;
            settled          <= 1'b0;
        end else begin
            state            <= state_n;
            shift_int        <= shift_int_n;
            acc              <= acc_n;
            cnt              <= cnt_n;
            signal_out       <= signal_out_n;
            signal_out_valid <= valid_n;
            settled          <= settled_n;
        end
    end

    always_comb begin
        state_n      = state;
        shift_int_n  = shift_int;
        acc_n        = acc;
        cnt_n        = cnt;
        signal_out_n = signal_out;
        valid_n      = 1'b0;
        settled_n    = settled;
        case (state)
            S_FLUSH: begin
                acc_n       = '0;
                cnt_n       = '0;
                settled_n   = 1'b0;
                shift_int_n = shift_cfg;
                if (enable) begin
                    state_n = S_ACCUM;
                end
            end
            S_ACCUM: begin
                // A config change is judged on the clamped value, so moving
                // between two out-of-range settings does not restart the block.
                if (!enable || (shift_cfg != shift_int)) begin
                    state_n = S_FLUSH;
                end else if (adc_in_valid) begin
                    if (cnt == last_cnt) begin
                        signal_out_n = WIDTH'(sum >>> shift_int);
                        valid_n      = 1'b1;
                        settled_n    = 1'b1;
                        acc_n        = '0;
                        cnt_n        = '0;
                    end else begin
                        acc_n = sum;
                        cnt_n = cnt + MAX_SHIFT'(1);
                    end
                end
            end
            default: begin
                state_n = S_FLUSH;
            end
        endcase
    end

endmodule

// File: tb/tb_decimating_boxcar_averager.sv
// Randomised and directed bench for decimating_boxcar_averager, checked
// against a queue-based block-mean reference model.
module tb_decimating_boxcar_averager;
    import decimating_boxcar_averager_pkg::*;

    localparam int W = word_width;

    typedef struct {
        logic        r;
        logic        e;
        int          sh;
        logic        v;
        logic [W-1:0] d;
    } stim_t;

    logic                        clk;
    logic                        rst;
    logic                        enable;
    logic [config_reg_width-1:0] decim_shift;
    logic [W-1:0]                adc_in;
    logic                        adc_in_valid;
    logic [W-1:0]                signal_out;
    logic                        signal_out_valid;
    logic                        settled;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit           m_active;
    int           m_shift;
    int           m_samples[$];
    bit           m_valid;
    bit           m_settled;
    logic [W-1:0] exp_q[$];

    decimating_boxcar_averager dut (
        .clk              (clk),
        .rst              (rst),
        .enable           (enable),
        .decim_shift      (decim_shift),
        .adc_in           (adc_in),
        .adc_in_valid     (adc_in_valid),
        .signal_out       (signal_out),
        .signal_out_valid (signal_out_valid),
        .settled          (settled)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t mk(input logic r, input logic e, input int sh,
                                 input logic v, input int d);
        stim_t s;
        s.r  = r;
        s.e  = e;
        s.sh = sh;
        s.v  = v;
        s.d  = W'(d);
        return s;
    endfunction

    function automatic logic [W-1:0] floor_mean(input longint total, input int sh);
        longint n;
        longint q;
        n = longint'(1) << sh;
        if (total >= 0) q = total / n;
        else            q = -((-total + n - 1) / n);
        return q[W-1:0];
    endfunction

    // Block-level behaviour: a flush cycle after any reset/disable/config change,
    // then exactly 2^shift accepted samples per output word.
    task automatic model_step(input stim_t s);
        int     cs;
        longint total;
        cs      = (s.sh > decim_max_shift) ? decim_max_shift : s.sh;
        m_valid = 1'b0;
        if (!s.r) begin
            m_active  = 1'b0;
            m_shift   = cs;
            m_samples.delete();
            m_settled = 1'b0;
        end else if (!m_active) begin
            m_samples.delete();
            m_settled = 1'b0;
            m_shift   = cs;
            m_active  = s.e;
        end else if (!s.e || cs != m_shift) begin
            m_active = 1'b0;
            m_samples.delete();
        end else if (s.v) begin
            m_samples.push_back(int'($signed(s.d)));
            if (m_samples.size() == (1 << m_shift)) begin
                total = 0;
                foreach (m_samples[i]) total += longint'(m_samples[i]);
                exp_q.push_back(floor_mean(total, m_shift));
                m_valid   = 1'b1;
                m_settled = 1'b1;
                m_samples.delete();
            end
        end
    endtask

    // Driver: apply one cycle of stimulus, advance the model, sample at edge+1.
    task automatic drive(input stim_t s);
        rst          = s.r;
        enable       = s.e;
        decim_shift  = config_reg_width'(s.sh);
        adc_in_valid = s.v;
        adc_in       = s.d;
        @(posedge clk);
        model_step(s);
        #1;
    endtask

    task automatic test_reset();
        drive(mk(0, 0, 2, 1, 123));
        drive(mk(0, 1, 2, 1, 456));
        model_step(mk(0, 0, 2, 0, 0));
        n_checks++;
        if (signal_out !== '0) begin
            n_fail++; $display("FAIL reset_out: got %h want 0000", signal_out);
        end
        n_checks++;
        if (signal_out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b want 0", signal_out_valid);
        end
        n_checks++;
        if (settled !== 1'b0) begin
            n_fail++; $display("FAIL reset_settled: got %b want 0", settled);
        end
    endtask

    task automatic test_basic();
        stim_t        q[$];
        logic [W-1:0] obs[$];
        logic [W-1:0] e;
        int           data[8] = '{4, 8, 12, 16, 1, 1, 1, 2};
        q.push_back(mk(1, 1, 2, 0, 0));
        foreach (data[i]) q.push_back(mk(1, 1, 2, 1, data[i]));
        q.push_back(mk(1, 1, 2, 0, 0));
        foreach (q[i]) begin
            drive(q[i]);
            n_checks++;
            if (signal_out_valid !== m_valid) begin
                n_fail++; $display("FAIL basic_valid cyc %0d: got %b want %b", i, signal_out_valid, m_valid);
            end
            n_checks++;
            if (settled !== m_settled) begin
                n_fail++; $display("FAIL basic_settled cyc %0d: got %b want %b", i, settled, m_settled);
            end
            if (m_valid) begin
                e = exp_q.pop_front();
                n_checks++;
                if (signal_out !== e) begin
                    n_fail++; $display("FAIL basic_out cyc %0d: got %h want %h", i, signal_out, e);
                end
            end
            if (signal_out_valid) obs.push_back(signal_out);
        end
        n_checks++;
        if (obs.size() != 2 || obs[0] !== 16'd10 || obs[1] !== 16'd1) begin
            n_fail++; $display("FAIL basic_means: got %p want 10,1", obs);
        end
        n_checks++;
        if (signal_out !== 16'd1) begin
            n_fail++; $display("FAIL basic_hold: got %h want 0001", signal_out);
        end
    endtask

    task automatic test_negative();
        stim_t        q[$];
        logic [W-1:0] obs[$];
        logic [W-1:0] e;
        int           data[4] = '{-1, -1, -2, -1};
        q.push_back(mk(1, 1, 1, 0, 0));
        q.push_back(mk(1, 1, 1, 0, 0));
        foreach (data[i]) q.push_back(mk(1, 1, 1, 1, data[i]));
        foreach (q[i]) begin
            drive(q[i]);
            n_checks++;
            if (signal_out_valid !== m_valid) begin
                n_fail++; $display("FAIL neg_valid cyc %0d: got %b want %b", i, signal_out_valid, m_valid);
            end
            n_checks++;
            if (settled !== m_settled) begin
                n_fail++; $display("FAIL neg_settled cyc %0d: got %b want %b", i, settled, m_settled);
            end
            if (m_valid) begin
                e = exp_q.pop_front();
                n_checks++;
                if (signal_out !== e) begin
                    n_fail++; $display("FAIL neg_out cyc %0d: got %h want %h", i, signal_out, e);
                end
            end
            if (signal_out_valid) obs.push_back(signal_out);
        end
        n_checks++;
        if (obs.size() != 2 || obs[0] !== 16'hFFFF || obs[1] !== 16'hFFFE) begin
            n_fail++; $display("FAIL neg_means: got %p want ffff,fffe", obs);
        end
    endtask

    // Full-scale blocks at the largest shift; the second block swaps the
    // config to another out-of-range value midway, which must not restart it.
    task automatic test_full_scale();
        stim_t        q[$];
        logic [W-1:0] obs[$];
        logic [W-1:0] e;
        q.push_back(mk(1, 1, 10, 0, 0));
        q.push_back(mk(1, 1, 10, 0, 0));
        for (int i = 0; i < 1024; i++) q.push_back(mk(1, 1, 10, 1, 16'h7FFF));
        for (int i = 0; i < 1024; i++) q.push_back(mk(1, 1, (i < 500) ? 12 : 15, 1, 16'h8000));
        foreach (q[i]) begin
            drive(q[i]);
            n_checks++;
            if (signal_out_valid !== m_valid) begin
                n_fail++; $display("FAIL full_valid cyc %0d: got %b want %b", i, signal_out_valid, m_valid);
            end
            if (m_valid) begin
                e = exp_q.pop_front();
                n_checks++;
                if (signal_out !== e) begin
                    n_fail++; $display("FAIL full_out cyc %0d: got %h want %h", i, signal_out, e);
                end
            end
            if (signal_out_valid) obs.push_back(signal_out);
        end
        n_checks++;
        if (obs.size() != 2 || obs[0] !== 16'h7FFF || obs[1] !== 16'h8000) begin
            n_fail++; $display("FAIL full_means: got %p want 7fff,8000", obs);
        end
    endtask

    task automatic test_passthrough();
        stim_t        q[$];
        logic [W-1:0] obs[$];
        logic [W-1:0] e;
        q.push_back(mk(1, 1, 0, 0, 0));
        q.push_back(mk(1, 1, 0, 0, 0));
        q.push_back(mk(1, 1, 0, 1, 5));
        q.push_back(mk(1, 1, 0, 0, 99));
        q.push_back(mk(1, 1, 0, 1, -3));
        q.push_back(mk(1, 1, 0, 1, 7));
        q.push_back(mk(1, 1, 0, 0, 0));
        foreach (q[i]) begin
            drive(q[i]);
            n_checks++;
            if (signal_out_valid !== m_valid) begin
                n_fail++; $display("FAIL pass_valid cyc %0d: got %b want %b", i, signal_out_valid, m_valid);
            end
            if (m_valid) begin
                e = exp_q.pop_front();
                n_checks++;
                if (signal_out !== e) begin
                    n_fail++; $display("FAIL pass_out cyc %0d: got %h want %h", i, signal_out, e);
                end
            end
            if (signal_out_valid) obs.push_back(signal_out);
        end
        n_checks++;
        if (obs.size() != 3 || obs[0] !== 16'd5 || obs[1] !== 16'hFFFD || obs[2] !== 16'd7) begin
            n_fail++; $display("FAIL pass_means: got %p want 0005,fffd,0007", obs);
        end
    endtask

    task automatic test_sparse();
        stim_t        q[$];
        logic [W-1:0] obs[$];
        logic [W-1:0] e;
        q.push_back(mk(1, 1, 2, 0, 0));
        q.push_back(mk(1, 1, 2, 0, 0));
        for (int i = 0; i < 14; i++) q.push_back(mk(1, 1, 2, (i % 3) == 2, 100 + i));
        foreach (q[i]) begin
            drive(q[i]);
            n_checks++;
            if (signal_out_valid !== m_valid) begin
                n_fail++; $display("FAIL sparse_valid cyc %0d: got %b want %b", i, signal_out_valid, m_valid);
            end
            if (m_valid) begin
                e = exp_q.pop_front();
                n_checks++;
                if (signal_out !== e) begin
                    n_fail++; $display("FAIL sparse_out cyc %0d: got %h want %h", i, signal_out, e);
                end
            end
            if (signal_out_valid) obs.push_back(signal_out);
        end
        // valid samples 102,105,108,111 -> 426/4 = 106
        n_checks++;
        if (obs.size() != 1 || obs[0] !== 16'd106) begin
            n_fail++; $display("FAIL sparse_means: got %p want 006a", obs);
        end
    endtask

    task automatic test_abort();
        stim_t        q[$];
        logic [W-1:0] obs[$];
        logic [W-1:0] e;
        q.push_back(mk(1, 1, 2, 1, 1000));
        q.push_back(mk(1, 1, 2, 1, 1000));
        q.push_back(mk(1, 1, 3, 1, 1000));
        q.push_back(mk(1, 1, 3, 1, 1000));
        for (int i = 1; i <= 8; i++) q.push_back(mk(1, 1, 3, 1, i));
        q.push_back(mk(1, 1, 2, 0, 0));
        q.push_back(mk(1, 1, 2, 0, 0));
        q.push_back(mk(1, 1, 2, 1, 2000));
        q.push_back(mk(1, 1, 2, 1, 2000));
        q.push_back(mk(0, 1, 2, 1, 2000));
        q.push_back(mk(1, 1, 2, 1, 2000));
        q.push_back(mk(1, 1, 2, 1, 10));
        q.push_back(mk(1, 1, 2, 1, 20));
        q.push_back(mk(1, 1, 2, 1, 30));
        q.push_back(mk(1, 1, 2, 1, 41));
        q.push_back(mk(1, 1, 2, 1, 3000));
        q.push_back(mk(1, 1, 2, 1, 3000));
        q.push_back(mk(1, 0, 2, 1, 3000));
        q.push_back(mk(1, 1, 2, 1, 3000));
        q.push_back(mk(1, 1, 2, 1, -5));
        q.push_back(mk(1, 1, 2, 1, -6));
        q.push_back(mk(1, 1, 2, 1, -7));
        q.push_back(mk(1, 1, 2, 1, -8));
        q.push_back(mk(1, 1, 2, 0, 0));
        foreach (q[i]) begin
            drive(q[i]);
            n_checks++;
            if (signal_out_valid !== m_valid) begin
                n_fail++; $display("FAIL abort_valid cyc %0d: got %b want %b", i, signal_out_valid, m_valid);
            end
            n_checks++;
            if (settled !== m_settled) begin
                n_fail++; $display("FAIL abort_settled cyc %0d: got %b want %b", i, settled, m_settled);
            end
            if (m_valid) begin
                e = exp_q.pop_front();
                n_checks++;
                if (signal_out !== e) begin
                    n_fail++; $display("FAIL abort_out cyc %0d: got %h want %h", i, signal_out, e);
                end
            end
            if (signal_out_valid) obs.push_back(signal_out);
        end
        n_checks++;
        if (obs.size() != 3 || obs[0] !== 16'd4 || obs[1] !== 16'd25 || obs[2] !== 16'hFFF9) begin
            n_fail++; $display("FAIL abort_means: got %p want 0004,0019,fff9", obs);
        end
    endtask

    task automatic test_random();
        stim_t        q[$];
        logic [W-1:0] e;
        int           sh;
        sh = 1;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 99) == 0) sh = $urandom_range(0, 3);
            q.push_back(mk(($urandom_range(0, 299) != 0), ($urandom_range(0, 149) != 0), sh,
                           ($urandom_range(0, 3) != 0), int'($urandom_range(0, 65535))));
        end
        foreach (q[i]) begin
            drive(q[i]);
            n_checks++;
            if (signal_out_valid !== m_valid) begin
                n_fail++; $display("FAIL rand_valid cyc %0d: got %b want %b", i, signal_out_valid, m_valid);
            end
            n_checks++;
            if (settled !== m_settled) begin
                n_fail++; $display("FAIL rand_settled cyc %0d: got %b want %b", i, settled, m_settled);
            end
            if (m_valid) begin
                e = exp_q.pop_front();
                n_checks++;
                if (signal_out !== e) begin
                    n_fail++; $display("FAIL rand_out cyc %0d: got %h want %h", i, signal_out, e);
                end
            end
        end
    endtask

    initial begin
        rst          = 1'b0;
        enable       = 1'b0;
        decim_shift  = '0;
        adc_in       = '0;
        adc_in_valid = 1'b0;
        m_active     = 1'b0;
        m_shift      = 0;
        m_valid      = 1'b0;
        m_settled    = 1'b0;
        test_reset();
        test_basic();
        test_negative();
        test_full_scale();
        test_passthrough();
        test_sparse();
        test_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
